// File: rtl/plab2_proc_tagged_regfile.sv
// plab2_proc_tagged_regfile
// Domain-tagged N-read / 1-write register file. Each entry remembers the
// security domain that wrote it, domain-0 readers never see domain-1 data, and
// a scrub FSM walks the array clearing every domain-1 entry.
module plab2_proc_tagged_regfile #(
  parameter int p_nbits      = 32,
  parameter int p_nregs      = 32,
  parameter int p_nrports    = 2,
  parameter int p_bypass     = 1,
  parameter int p_zero_reg   = 1,
  parameter int p_auto_scrub = 1,
  localparam int AW          = $clog2(p_nregs)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           domain,
  input  logic [p_nrports*AW-1:0]        read_addr,
  output logic [p_nrports*p_nbits-1:0]   read_data,
  output logic [p_nrports-1:0]           read_tag,
  input  logic                           write_en,
  input  logic [AW-1:0]                  write_addr,
  input  logic [p_nbits-1:0]             write_data,
  input  logic                           scrub_req,
  output logic                           scrub_busy,
  output logic                           scrub_done
);

  localparam logic [0:0]    S_IDLE  = 1'b0;
  localparam logic [0:0]    S_SCRUB = 1'b1;
  localparam logic [AW-1:0] LAST_IDX = AW'(p_nregs - 1);

  logic [p_nbits-1:0] data_q [p_nregs];
  logic [p_nregs-1:0] tag_q;

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          done_q, done_d;
  logic          prev_dom_q;

  logic          wr_ok;
  logic          scrub_start;

  // Addresses beyond the last entry are neither readable nor writable.
  function automatic logic in_range(input logic [AW-1:0] a);
    return (32'(a) < 32'(p_nregs));
  endfunction

  assign wr_ok = write_en && in_range(write_addr) &&
                 !((p_zero_reg != 0) && (write_addr == '0));

  // A falling domain edge (secure -> normal) kicks off a scrub when enabled.
  assign scrub_start = scrub_req ||
                       ((p_auto_scrub != 0) && prev_dom_q && !domain);

  assign scrub_busy = (state_q == S_SCRUB);
  assign scrub_done = done_q;

  // Entry storage: a write to the entry being scrubbed takes precedence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < p_nregs; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < p_nregs; i++) begin
        if (wr_ok && (write_addr == AW'(i))) begin
          data_q[i] <= write_data;
          tag_q[i]  <= domain;
        end else if ((state_q == S_SCRUB) && (idx_q == AW'(i)) && tag_q[i]) begin
          data_q[i] <= '0;
          tag_q[i]  <= 1'b0;
        end
      end
    end
  end

  // Scrub FSM next-state: one entry per cycle, requests ignored while busy.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (scrub_start) begin
          state_d = S_SCRUB;
          idx_d   = '0;
        end
      end
      S_SCRUB: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Scrub FSM state, index, done pulse and previous-domain tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      done_q     <= 1'b0;
      prev_dom_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      done_q     <= done_d;
      prev_dom_q <= domain;
    end
  end

  // Read ports: zero register, range check, bypass, storage, then domain mask.
  always_comb begin
    read_data = '0;
    read_tag  = '0;
    for (int p = 0; p < p_nrports; p++) begin : g_rd
      logic [AW-1:0]      ra;
      logic [p_nbits-1:0] sel_d;
      logic               sel_t;
      ra    = read_addr[p*AW +: AW];
      sel_d = '0;
      sel_t = 1'b0;
      if ((p_zero_reg != 0) && (ra == '0)) begin
        sel_d = '0;
        sel_t = 1'b0;
      end else if (!in_range(ra)) begin
        sel_d = '0;
        sel_t = 1'b0;
      end else if ((p_bypass != 0) && write_en && (write_addr == ra)) begin
        sel_d = write_data;
        sel_t = domain;
      end else begin
        sel_d = data_q[ra];
        sel_t = tag_q[ra];
      end
      if (sel_t && !domain) begin
        sel_d = '0;
      end
      read_data[p*p_nbits +: p_nbits] = sel_d;
      read_tag[p]                     = sel_t;
    end
  end

endmodule

// File: tb/tb_plab2_proc_tagged_regfile.sv
// Directed bench for plab2_proc_tagged_regfile: writes, bypass, zero register,
// domain masking, manual and automatic scrubs, reset abort, out-of-range access.
module tb_plab2_proc_tagged_regfile;

  localparam int AW = 5;

  logic          clk;
  logic          reset;
  logic          domain;
  logic [2*AW-1:0] read_addr;
  logic [63:0]   read_data;
  logic [1:0]    read_tag;
  logic          write_en;
  logic [AW-1:0] write_addr;
  logic [31:0]   write_data;
  logic          scrub_req;
  logic          scrub_busy;
  logic          scrub_done;

  // Second, non-power-of-two instance for out-of-range addressing.
  logic [AW-1:0] s_ra;
  logic [31:0]   s_rd;
  logic [0:0]    s_rt;
  logic          s_we;
  logic [AW-1:0] s_wa;
  logic [31:0]   s_wd;
  logic          s_busy;
  logic          s_done;

  int n_vec = 0;
  int n_err = 0;
  int busy_cnt, done_cnt, done_at;

  plab2_proc_tagged_regfile dut (
    .clk        (clk),
    .reset      (reset),
    .domain     (domain),
    .read_addr  (read_addr),
    .read_data  (read_data),
    .read_tag   (read_tag),
    .write_en   (write_en),
    .write_addr (write_addr),
    .write_data (write_data),
    .scrub_req  (scrub_req),
    .scrub_busy (scrub_busy),
    .scrub_done (scrub_done)
  );

  plab2_proc_tagged_regfile #(.p_nregs(20), .p_nrports(1)) u_small (
    .clk        (clk),
    .reset      (reset),
    .domain     (domain),
    .read_addr  (s_ra),
    .read_data  (s_rd),
    .read_tag   (s_rt),
    .write_en   (s_we),
    .write_addr (s_wa),
    .write_data (s_wd),
    .scrub_req  (1'b0),
    .scrub_busy (s_busy),
    .scrub_done (s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_port(input string tag, input int p, input logic [31:0] ed, input logic et);
    chk({tag, "_data"}, read_data[p*32 +: 32], ed);
    chk({tag, "_tag"}, {31'd0, read_tag[p]}, {31'd0, et});
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    read_addr = {a1, a0};
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_scrub(input int k);
    busy_cnt += int'(scrub_busy);
    if (scrub_done) begin
      done_cnt++;
      done_at = k;
    end
  endtask

  initial begin
    reset = 1'b1; domain = 1'b0; write_en = 1'b0; write_addr = '0;
    write_data = '0; scrub_req = 1'b0; set_ra(5'd0, 5'd5);
    s_ra = '0; s_we = 1'b0; s_wa = '0; s_wd = '0;
    #3;
    chk("rst_busy", {31'd0, scrub_busy}, 32'd0);
    chk("rst_done", {31'd0, scrub_done}, 32'd0);
    chk_port("rst_r5", 1, 32'h0, 1'b0);
    nxt(); nxt();
    reset = 1'b0;

    // Write r5 in domain 0; bypass visible the same cycle.
    write_en = 1'b1; write_addr = 5'd5; write_data = 32'hDEAD_BEEF; set_ra(5'd3, 5'd5);
    #1 chk_port("byp_r5", 1, 32'hDEAD_BEEF, 1'b0);
    nxt();
    write_addr = 5'd0; write_data = 32'hFFFF_FFFF; set_ra(5'd0, 5'd5);
    #1 chk_port("zero_byp", 0, 32'h0, 1'b0);
    chk_port("r5_stored", 1, 32'hDEAD_BEEF, 1'b0);
    nxt();
    // Secure writes to r7, r2, r9.
    domain = 1'b1; write_addr = 5'd7; write_data = 32'h1234; set_ra(5'd0, 5'd7);
    #1 chk_port("r0_after_wr", 0, 32'h0, 1'b0);
    chk_port("byp_r7_sec", 1, 32'h1234, 1'b1);
    nxt();
    write_addr = 5'd2; write_data = 32'hAAAA;
    #1 chk_port("r7_sec", 1, 32'h1234, 1'b1);
    nxt();
    write_addr = 5'd9; write_data = 32'h9999;
    nxt();
    // Drop to domain 0: masking, and an automatic scrub starts at this edge.
    domain = 1'b0; write_addr = 5'd4; write_data = 32'h4444; set_ra(5'd7, 5'd4);
    #1 chk_port("r7_masked", 0, 32'h0, 1'b1);
    chk_port("byp_r4", 1, 32'h4444, 1'b0);
    chk("auto_pre_busy", {31'd0, scrub_busy}, 32'd0);
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int k = 1; k <= 34; k++) begin
      nxt();
      write_en = 1'b0; scrub_req = 1'b0;
      sample_scrub(k);
      if (k == 2) begin
        set_ra(5'd0, 5'd2);
        #1 chk_port("scr_r2_masked", 1, 32'h0, 1'b1);
      end
      if (k == 5) begin
        write_en = 1'b1; write_addr = 5'd3; write_data = 32'h55; set_ra(5'd3, 5'd0);
        #1 chk_port("byp_r3", 0, 32'h55, 1'b0);
      end
      if (k == 10) begin
        write_en = 1'b1; write_addr = 5'd9; write_data = 32'h77;
      end
      if (k == 15) scrub_req = 1'b1;
      if (k == 20) begin
        set_ra(5'd0, 5'd7);
        #1 chk_port("scr_r7_clr", 1, 32'h0, 1'b0);
      end
    end
    chk("auto_busy_cycles", busy_cnt, 32'd32);
    chk("auto_done_count", done_cnt, 32'd1);
    chk("auto_done_at", done_at, 32'd33);
    nxt();
    domain = 1'b1; set_ra(5'd2, 5'd9);
    #1 chk_port("auto_r2", 0, 32'h0, 1'b0);
    chk_port("auto_r9_wr_wins", 1, 32'h77, 1'b0);
    nxt();
    set_ra(5'd7, 5'd4);
    #1 chk_port("auto_r7", 0, 32'h0, 1'b0);
    chk_port("auto_r4", 1, 32'h4444, 1'b0);

    // Manual scrub in domain 1.
    nxt();
    write_en = 1'b1; write_addr = 5'd2; write_data = 32'h22;
    nxt();
    write_addr = 5'd9; write_data = 32'h99;
    nxt();
    write_en = 1'b0; scrub_req = 1'b1; set_ra(5'd9, 5'd2);
    #1 chk_port("man_pre_r9", 0, 32'h99, 1'b1);
    chk_port("man_pre_r2", 1, 32'h22, 1'b1);
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int k = 1; k <= 34; k++) begin
      nxt();
      scrub_req = 1'b0;
      sample_scrub(k);
    end
    chk("man_busy_cycles", busy_cnt, 32'd32);
    chk("man_done_count", done_cnt, 32'd1);
    chk("man_done_at", done_at, 32'd33);
    nxt();
    set_ra(5'd2, 5'd9);
    #1 chk_port("man_r2", 0, 32'h0, 1'b0);
    chk_port("man_r9", 1, 32'h0, 1'b0);
    set_ra(5'd4, 5'd5);
    #1 chk_port("man_r4", 0, 32'h4444, 1'b0);
    chk_port("man_r5", 1, 32'hDEAD_BEEF, 1'b0);

    // Reset in the middle of a scrub (idx 10).
    nxt();
    scrub_req = 1'b1;
    nxt();
    scrub_req = 1'b0;
    repeat (10) nxt();
    chk("abort_pre_busy", {31'd0, scrub_busy}, 32'd1);
    reset = 1'b1;
    #1 chk("abort_busy", {31'd0, scrub_busy}, 32'd0);
    chk("abort_done", {31'd0, scrub_done}, 32'd0);
    chk_port("abort_r4", 0, 32'h0, 1'b0);
    chk_port("abort_r5", 1, 32'h0, 1'b0);
    nxt();
    reset = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int k = 1; k <= 40; k++) begin
      nxt();
      sample_scrub(k);
    end
    chk("post_abort_busy", busy_cnt, 32'd0);
    chk("post_abort_done", done_cnt, 32'd0);

    // Out-of-range addressing on the 20-entry instance.
    s_we = 1'b1; s_wa = 5'd19; s_wd = 32'h1919;
    nxt();
    s_wa = 5'd25; s_wd = 32'h0BAD; s_ra = 5'd25;
    #1 chk("oor_byp_data", s_rd, 32'h0);
    chk("oor_byp_tag", {31'd0, s_rt}, 32'd0);
    nxt();
    s_we = 1'b0; s_ra = 5'd19;
    #1 chk("small_r19", s_rd, 32'h1919);
    s_ra = 5'd9;
    #1 chk("small_r9", s_rd, 32'h0);
    s_ra = 5'd25;
    #1 chk("oor_rd_data", s_rd, 32'h0);
    chk("oor_rd_tag", {31'd0, s_rt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
